// File: rtl/evm_pkg.sv
// Shared EVM definitions: candidate count, button-conditioner FSM states and
// the default debounce length.
package evm_pkg;

  localparam int unsigned NUM_CANDIDATES          = 3;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } cond_state_e;

  function automatic logic [1:0] count_ones(input logic [NUM_CANDIDATES-1:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button: 2-flop synchroniser, counter debounce and a one-cycle
// pulse on the edge where the debounced level rises.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic stable_o,
  output logic new_press_o,
  output logic quiet_o
);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             new_q, new_d;
  logic             flip;

  always_comb begin
    flip     = (sync2_q != stable_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    stable_d = flip ? ~stable_q : stable_q;
    new_d    = flip && !stable_q;
    if (sync2_q == stable_q || flip) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      new_q    <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      new_q    <= new_d;
    end
  end

  assign stable_o    = stable_q;
  assign new_press_o = new_q;
  // Nothing released-but-not-yet-debounced is still moving through the pipe.
  assign quiet_o     = !sync1_q && !sync2_q && !stable_q;

endmodule

// File: rtl/vote_button_conditioner.sv
// Conditions the three candidate buttons into one-hot, single-cycle vote
// pulses with simultaneous-press rejection and a per-press hold lockout.
module vote_button_conditioner
  import evm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_1,
  input  logic btn_2,
  input  logic btn_3,
  input  logic accept_en,
  output logic vote_candidate_1,
  output logic vote_candidate_2,
  output logic vote_candidate_3,
  output logic multi_press,
  output logic btn_busy
);

  if (DEBOUNCE_CYCLES < 2 || (2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_param_check
    $error("vote_button_conditioner: bad DEBOUNCE_CYCLES/CNT_W");
  end

  logic [NUM_CANDIDATES-1:0] btn_raw, stable_w, new_w, quiet_w;

  assign btn_raw = {btn_3, btn_2, btn_1};

  for (genvar g = 0; g < NUM_CANDIDATES; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk        (clk),
      .rst        (rst),
      .btn_i      (btn_raw[g]),
      .stable_o   (stable_w[g]),
      .new_press_o(new_w[g]),
      .quiet_o    (quiet_w[g])
    );
  end

  cond_state_e               state_q, state_d;
  logic [NUM_CANDIDATES-1:0] vote_q, vote_d;
  logic                      multi_q, multi_d;
  logic                      busy_q;
  logic                      settled_q;
  logic [1:0]                n_new;

  always_comb begin
    state_d = state_q;
    vote_d  = '0;
    multi_d = 1'b0;
    n_new   = count_ones(new_w);
    unique case (state_q)
      ST_IDLE: begin
        if (n_new == 2'd1) begin
          vote_d  = accept_en ? new_w : '0;
          state_d = ST_LOCK;
        end else if (n_new >= 2'd2) begin
          multi_d = 1'b1;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        // Leaving LOCK also waits for the synchronisers to be empty and, after
        // reset, for one cycle of real samples, so a button held through reset
        // cannot sneak a vote in before its stable level has had time to rise.
        if (settled_q && (&quiet_w) && (stable_w == '0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_LOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_LOCK;
      vote_q    <= '0;
      multi_q   <= 1'b0;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vote_q    <= vote_d;
      multi_q   <= multi_d;
      busy_q    <= (state_d == ST_LOCK);
      settled_q <= 1'b1;
    end
  end

  assign vote_candidate_1 = vote_q[0];
  assign vote_candidate_2 = vote_q[1];
  assign vote_candidate_3 = vote_q[2];
  assign multi_press      = multi_q;
  assign btn_busy         = busy_q;

endmodule

// File: tb/tb_vote_button_conditioner.sv
// Scoreboard bench for vote_button_conditioner with a 4-cycle debounce.
module tb_vote_button_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned LAT = DEB + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_1 = 1'b0, btn_2 = 1'b0, btn_3 = 1'b0;
  logic accept_en = 1'b0;
  logic vote_candidate_1, vote_candidate_2, vote_candidate_3;
  logic multi_press, btn_busy;

  vote_button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_1           (btn_1),
    .btn_2           (btn_2),
    .btn_3           (btn_3),
    .accept_en       (accept_en),
    .vote_candidate_1(vote_candidate_1),
    .vote_candidate_2(vote_candidate_2),
    .vote_candidate_3(vote_candidate_3),
    .multi_press     (multi_press),
    .btn_busy        (btn_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vec;  // {multi, v3, v2, v1}
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] obs;
  ev_t        ev;

  always @(posedge clk) cyc++;

  // Every output pulse is matched against the next expected event.
  always @(negedge clk) begin
    obs = {multi_press, vote_candidate_3, vote_candidate_2, vote_candidate_1};
    if (cyc > 2 && obs !== 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got %b at cycle %0d, required no pulse", obs, cyc);
      end else begin
        ev = exp_q.pop_front();
        if (obs !== ev.vec || cyc !== ev.cyc) begin
          errors++;
          $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d",
                   obs, cyc, ev.vec, ev.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic [3:0] vec, input int at);
    ev_t e;
    e.vec = vec;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(2);
    checks++;
    if ({multi_press, vote_candidate_3, vote_candidate_2, vote_candidate_1, btn_busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 00000",
               {multi_press, vote_candidate_3, vote_candidate_2, vote_candidate_1, btn_busy});
    end
    rst = 1'b1;
    tick(4);
    checks++;
    if (btn_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b, required 0", btn_busy);
    end
  endtask

  task automatic test_basic_vote;
    int c, r;
    accept_en = 1'b1;
    btn_1 = 1'b1;
    c = cyc;
    expect_pulse(4'b0001, c + LAT);
    tick(LAT - 1);
    checks++;
    if (btn_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_before: got %b, required 0", btn_busy);
    end
    tick(1);
    checks++;
    if (btn_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_at_pulse: got %b, required 1", btn_busy);
    end
    tick(20 - LAT);
    btn_1 = 1'b0;
    r = cyc;
    tick(LAT - 1);
    checks++;
    if (btn_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_release_hold: got %b at cycle %0d, required 1", btn_busy, cyc - r);
    end
    tick(1);
    checks++;
    if (btn_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_release_end: got %b, required 0", btn_busy);
    end
    tick(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_missing: got %0d pending pulses, required 0", exp_q.size());
    end
  endtask

  task automatic test_bounce;
    int c;
    accept_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      btn_2 = 1'b1;
      tick(2);
      btn_2 = 1'b0;
      tick(2);
    end
    btn_2 = 1'b1;
    c = cyc;
    expect_pulse(4'b0010, c + LAT);
    tick(15);
    btn_2 = 1'b0;
    tick(12);
    checks++;
    if (exp_q.size() != 0 || btn_busy !== 1'b0) begin
      errors++;
      $display("FAIL bounce_end: got %0d pending, busy %b, required 0 pending, busy 0",
               exp_q.size(), btn_busy);
    end
  endtask

  task automatic test_simultaneous;
    int c;
    accept_en = 1'b1;
    btn_2 = 1'b1;
    btn_3 = 1'b1;
    c = cyc;
    expect_pulse(4'b1000, c + LAT);
    tick(12);
    btn_2 = 1'b0;
    tick(3);
    btn_3 = 1'b0;
    tick(LAT - 1);
    checks++;
    if (btn_busy !== 1'b1) begin
      errors++;
      $display("FAIL simul_busy_hold: got %b, required 1", btn_busy);
    end
    tick(1);
    checks++;
    if (btn_busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_busy_end: got %b, required 0", btn_busy);
    end
    tick(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL simul_missing: got %0d pending pulses, required 0", exp_q.size());
    end
  endtask

  task automatic test_staggered;
    int c;
    accept_en = 1'b1;
    btn_1 = 1'b1;
    c = cyc;
    expect_pulse(4'b0001, c + LAT);
    tick(3);
    btn_3 = 1'b1;
    tick(15);
    btn_1 = 1'b0;
    btn_3 = 1'b0;
    tick(12);
    btn_3 = 1'b1;
    c = cyc;
    expect_pulse(4'b0100, c + LAT);
    tick(12);
    btn_3 = 1'b0;
    tick(12);
    checks++;
    if (exp_q.size() != 0 || btn_busy !== 1'b0) begin
      errors++;
      $display("FAIL stagger_end: got %0d pending, busy %b, required 0 pending, busy 0",
               exp_q.size(), btn_busy);
    end
  endtask

  task automatic test_not_ready;
    int c;
    accept_en = 1'b0;
    btn_1 = 1'b1;
    tick(10);
    accept_en = 1'b1;
    tick(8);
    checks++;
    if (btn_busy !== 1'b1) begin
      errors++;
      $display("FAIL notready_busy: got %b, required 1", btn_busy);
    end
    btn_1 = 1'b0;
    tick(12);
    btn_1 = 1'b1;
    c = cyc;
    expect_pulse(4'b0001, c + LAT);
    tick(12);
    btn_1 = 1'b0;
    tick(12);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL notready_missing: got %0d pending pulses, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_hold;
    int c;
    accept_en = 1'b1;
    btn_2 = 1'b1;
    c = cyc;
    expect_pulse(4'b0010, c + LAT);
    tick(9);
    rst = 1'b0;
    tick(1);
    checks++;
    if ({multi_press, vote_candidate_3, vote_candidate_2, vote_candidate_1, btn_busy} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b, required 00000",
               {multi_press, vote_candidate_3, vote_candidate_2, vote_candidate_1, btn_busy});
    end
    rst = 1'b1;
    tick(5);
    checks++;
    if (btn_busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_locked: got %b, required 1", btn_busy);
    end
    tick(15);
    btn_2 = 1'b0;
    tick(12);
    checks++;
    if (btn_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: got %b, required 0", btn_busy);
    end
    btn_2 = 1'b1;
    c = cyc;
    expect_pulse(4'b0010, c + LAT);
    tick(12);
    btn_2 = 1'b0;
    tick(12);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_missing: got %0d pending pulses, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_vote();
    test_bounce();
    test_simultaneous();
    test_staggered();
    test_not_ready();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
